alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 19 +
 rtl/alu.sv | 33 +++
 rtl/alu_arbiter_rr_arb2.sv | 23 ++
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU and the two-requester ALU arbiter.
//   - ALU op encodings (ADD, SUB, AND, OR, SLT)
//   - arbiter FSM state encoding, also exported on the arbiter's debug port
package alu_arbiter_pkg;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU.
// Ports:
//   a, b  : operands (W bits)
//   op    : operation, encodings from alu_arbiter_pkg
//   res   : result (W bits); unknown op codes give 0
//   zero  : res == 0
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] res,
  output logic         zero
);

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_SLT:  res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: res = '0;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant.
// Ports:
//   valid : request lines, bit N = requester N
//   last  : requester granted most recently (pointer held by the caller)
//   gnt   : one-hot grant, zero when nothing is valid
// A lone requester always wins; on a tie the one not granted last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared external ALU, one operation at a time.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   reqN_valid/a/b/op       : requester N operation
//   reqN_ready              : one-cycle acceptance pulse (only in IDLE)
//   rspN_valid/res/zero     : captured result, held until rspN_ready
//   rspN_ready              : requester N consumes its response
//   alu_a/alu_b/alu_op      : registered drive to the shared ALU
//   alu_res/alu_zero        : shared ALU outputs
//   dbg_state               : current FSM state
// Handshake: a request transfers on the cycle reqN_valid && reqN_ready; a
// response transfers on the cycle rspN_valid && rspN_ready. rspN_ready while
// rspN_valid is low has no effect.
// Timing: grant (IDLE) -> EXEC (ALU settles) -> WAIT (capture) -> RESP, so
// rspN_valid rises three cycles after the reqN_ready pulse.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         req1_ready,
  output logic         rsp0_valid,
  output logic [W-1:0] rsp0_res,
  output logic         rsp0_zero,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp1_res,
  output logic         rsp1_zero,
  input  logic         rsp1_ready,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_res,
  input  logic         alu_zero,
  output state_t       dbg_state
);

  state_t     state;
  logic       last_gnt;  // 1 = requester 1 granted most recently
  logic       cur;       // requester owning the operation in flight
  logic [1:0] gnt;
  logic       take;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .last  (last_gnt),
    .gnt   (gnt)
  );

  // The acceptance pulse has to coincide with the cycle the operands are
  // latched, so it is decoded from the registered state. Gating with reset
  // keeps reset dominant over a request seen in IDLE.
  assign take       = (state == ST_IDLE) && !reset;
  assign req0_ready = take && gnt[0];
  assign req1_ready = take && gnt[1];
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_gnt   <= 1'b1;
      cur        <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_res   <= '0;
      rsp0_zero  <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_res   <= '0;
      rsp1_zero  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_ADD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            cur      <= gnt[1];
            last_gnt <= gnt[1];
            alu_a    <= gnt[1] ? req1_a  : req0_a;
            alu_b    <= gnt[1] ? req1_b  : req0_b;
            alu_op   <= gnt[1] ? req1_op : req0_op;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: state <= ST_WAIT;
        ST_WAIT: begin
          if (cur) begin
            rsp1_valid <= 1'b1;
            rsp1_res   <= alu_res;
            rsp1_zero  <= alu_zero;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_res   <= alu_res;
            rsp0_zero  <= alu_zero;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (cur && rsp1_ready) begin
            rsp1_valid <= 1'b0;
            state      <= ST_IDLE;
          end else if (!cur && rsp0_ready) begin
            rsp0_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W  = 32;
  localparam int EW = W + 2;  // {id, zero, res}

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_res, rsp1_res;
  logic         rsp0_zero, rsp1_zero;
  logic         rsp0_ready, rsp1_ready;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [2:0]   alu_op;
  logic         alu_zero;
  state_t       dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_res(rsp0_res), .rsp0_zero(rsp0_zero),
    .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_res(rsp1_res), .rsp1_zero(rsp1_zero),
    .rsp1_ready(rsp1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .dbg_state(dbg_state)
  );

  alu #(.W(W)) u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .res(alu_res), .zero(alu_zero)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] model(input logic id, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [2:0] op);
    logic [W-1:0] r;
    case (op)
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b111:  r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return {id, (r == '0), r};
  endfunction

  task automatic pop_cmp(input logic id, input logic [W-1:0] res, input logic zero);
    logic [EW-1:0] e;
    check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rsp_id",   64'(id),   64'(e[EW-1]));
      check("rsp_res",  64'(res),  64'(e[W-1:0]));
      check("rsp_zero", 64'(zero), 64'(e[W]));
    end
  endtask

  // Monitor: protocol invariants plus scoreboard pop on each response handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_ready || req1_ready) begin
        check("rdy_overlap", 64'(req0_ready & req1_ready), 64'd0);
        check("rdy_in_idle", 64'(dbg_state), 64'(ST_IDLE));
      end
      if (rsp0_valid || rsp1_valid)
        check("rsp_overlap", 64'(rsp0_valid & rsp1_valid), 64'd0);
      if (rsp0_valid && rsp0_ready) pop_cmp(1'b0, rsp0_res, rsp0_zero);
      if (rsp1_valid && rsp1_ready) pop_cmp(1'b1, rsp1_res, rsp1_zero);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_req(input int id, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2:0] op);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int id, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      next_cycle();
      sample();
      seen = (id == 0) ? req0_ready : req1_ready;
    end
    check($sformatf("grant%0d_seen", id), 64'(seen), 64'd1);
  endtask

  task automatic wait_rsp(input int id, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      next_cycle();
      sample();
      seen = (id == 0) ? rsp0_valid : rsp1_valid;
    end
    check($sformatf("rsp%0d_arrive", id), 64'(seen), 64'd1);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) begin
      next_cycle();
      sample();
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a0, b0, a1, b1;
    int g;

    reset = 1'b1;
    drive_req(0, 1'b0, '0, '0, 3'b000);
    drive_req(1, 1'b0, '0, '0, 3'b000);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    apply_reset();

    // Reset state
    sample();
    check("rst_state",  64'(dbg_state),  64'(ST_IDLE));
    check("rst_rdy0",   64'(req0_ready), 64'd0);
    check("rst_rdy1",   64'(req1_ready), 64'd0);
    check("rst_rspv0",  64'(rsp0_valid), 64'd0);
    check("rst_rspv1",  64'(rsp1_valid), 64'd0);
    check("rst_res0",   64'(rsp0_res),   64'd0);
    check("rst_res1",   64'(rsp1_res),   64'd0);
    check("rst_zero0",  64'(rsp0_zero),  64'd0);
    check("rst_zero1",  64'(rsp1_zero),  64'd0);
    check("rst_alu_a",  64'(alu_a),      64'd0);
    check("rst_alu_b",  64'(alu_b),      64'd0);
    check("rst_alu_op", 64'(alu_op),     64'b010);

    // 5 + 3 on requester 0, latency of three cycles
    next_cycle();
    rsp0_ready = 1'b1;
    drive_req(0, 1'b1, 32'd5, 32'd3, 3'b010);
    sample();
    check("s31_rdy0", 64'(req0_ready), 64'd1);
    check("s31_rdy1", 64'(req1_ready), 64'd0);
    exp_q.push_back(model(1'b0, 32'd5, 32'd3, 3'b010));
    next_cycle();
    drive_req(0, 1'b0, '0, '0, 3'b000);
    sample();
    check("s31_lat1",   64'(rsp0_valid), 64'd0);
    check("s31_alu_a",  64'(alu_a),      64'd5);
    check("s31_alu_b",  64'(alu_b),      64'd3);
    check("s31_alu_op", 64'(alu_op),     64'b010);
    next_cycle();
    sample();
    check("s31_lat2", 64'(rsp0_valid), 64'd0);
    next_cycle();
    sample();
    check("s31_lat3",  64'(rsp0_valid), 64'd1);
    check("s31_res",   64'(rsp0_res),   64'd8);
    check("s31_zero",  64'(rsp0_zero),  64'd0);
    next_cycle();
    sample();
    check("s31_clear", 64'(rsp0_valid), 64'd0);
    check("s31_hold_a", 64'(alu_a),     64'd5);

    // Tie after reset: requester 0 first, then requester 1 (7 - 7 = 0)
    apply_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    exp_q.push_back(model(1'b0, 32'd12, 32'd10, 3'b000));
    exp_q.push_back(model(1'b1, 32'd7, 32'd7, 3'b110));
    drive_req(0, 1'b1, 32'd12, 32'd10, 3'b000);
    drive_req(1, 1'b1, 32'd7, 32'd7, 3'b110);
    sample();
    check("s32_tie_rdy0", 64'(req0_ready), 64'd1);
    check("s32_tie_rdy1", 64'(req1_ready), 64'd0);
    wait_grant(1, 10);
    next_cycle();
    drive_req(0, 1'b0, '0, '0, 3'b000);
    drive_req(1, 1'b0, '0, '0, 3'b000);
    wait_drain(20);

    // Six back-to-back contended grants must alternate 0,1,0,1,0,1
    a0 = W'($urandom); b0 = W'($urandom);
    a1 = W'($urandom); b1 = W'($urandom);
    for (int k = 0; k < 6; k++)
      exp_q.push_back((k % 2 == 0) ? model(1'b0, a0, b0, 3'b010) : model(1'b1, a1, b1, 3'b001));
    next_cycle();
    drive_req(0, 1'b1, a0, b0, 3'b010);
    drive_req(1, 1'b1, a1, b1, 3'b001);
    g = 0;
    for (int i = 0; i < 60; i++) begin
      sample();
      if (req0_ready || req1_ready) g++;
      if (g == 6) break;
      next_cycle();
    end
    check("s33_grants", 64'(g), 64'd6);
    next_cycle();
    drive_req(0, 1'b0, '0, '0, 3'b000);
    drive_req(1, 1'b0, '0, '0, 3'b000);
    wait_drain(20);

    // SLT -1 < 1 on requester 1 with a stalled consumer
    next_cycle();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b0;
    drive_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111);
    sample();
    check("s34_rdy1", 64'(req1_ready), 64'd1);
    exp_q.push_back(model(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111));
    next_cycle();
    drive_req(1, 1'b0, '0, '0, 3'b000);
    drive_req(0, 1'b1, 32'h11, 32'h22, 3'b001);
    wait_rsp(1, 10);
    for (int k = 0; k < 5; k++) begin
      check("s34_hold_v",   64'(rsp1_valid), 64'd1);
      check("s34_hold_res", 64'(rsp1_res),   64'd1);
      check("s34_hold_z",   64'(rsp1_zero),  64'd0);
      check("s34_no_grant", 64'(req0_ready), 64'd0);
      check("s34_rsp0_off", 64'(rsp0_valid), 64'd0);
      next_cycle();
      sample();
    end
    exp_q.push_back(model(1'b0, 32'h11, 32'h22, 3'b001));
    next_cycle();
    rsp1_ready = 1'b1;
    sample();
    check("s34_hs_rdy0", 64'(req0_ready), 64'd0);
    next_cycle();
    sample();
    check("s34_regrant", 64'(req0_ready), 64'd1);
    next_cycle();
    drive_req(0, 1'b0, '0, '0, 3'b000);
    wait_drain(20);

    // Reset while in EXEC aborts the operation
    next_cycle();
    drive_req(0, 1'b1, 32'd9, 32'd9, 3'b000);
    sample();
    check("s35_rdy0", 64'(req0_ready), 64'd1);
    next_cycle();
    drive_req(0, 1'b0, '0, '0, 3'b000);
    reset = 1'b1;
    sample();
    check("s35_in_exec", 64'(dbg_state), 64'(ST_EXEC));
    next_cycle();
    reset = 1'b0;
    sample();
    check("s35_state",  64'(dbg_state),  64'(ST_IDLE));
    check("s35_alu_a",  64'(alu_a),      64'd0);
    check("s35_alu_b",  64'(alu_b),      64'd0);
    check("s35_alu_op", 64'(alu_op),     64'b010);
    for (int k = 0; k < 4; k++) begin
      check("s35_no_rsp", 64'(rsp0_valid | rsp1_valid), 64'd0);
      next_cycle();
      sample();
    end
    exp_q.push_back(model(1'b1, 32'd100, 32'd58, 3'b110));
    next_cycle();
    drive_req(1, 1'b1, 32'd100, 32'd58, 3'b110);
    sample();
    check("s35_after_rdy1", 64'(req1_ready), 64'd1);
    next_cycle();
    drive_req(1, 1'b0, '0, '0, 3'b000);
    wait_drain(20);

    // Reset while a response is held in RESP clears it
    next_cycle();
    rsp1_ready = 1'b0;
    drive_req(1, 1'b1, 32'd4, 32'd4, 3'b010);
    sample();
    check("rr_rdy1", 64'(req1_ready), 64'd1);
    next_cycle();
    drive_req(1, 1'b0, '0, '0, 3'b000);
    wait_rsp(1, 10);
    check("rr_res_pre", 64'(rsp1_res), 64'd8);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    sample();
    check("rr_rspv1", 64'(rsp1_valid), 64'd0);
    check("rr_res1",  64'(rsp1_res),   64'd0);
    check("rr_alu_a", 64'(alu_a),      64'd0);
    check("rr_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
